// File: rtl/ifetch_queue.sv
// Instruction fetch front end: drives the instruction memory from fetch_pc and
// buffers returned words (with fault info) in a small FIFO toward decode.
module ifetch_queue #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val,
  output logic        fetch_halted
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  entry_t      mem [FIFO_DEPTH];
  entry_t      new_entry;
  entry_t      head;
  logic [63:0] fetch_pc;
  logic        halted;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push, misaligned, push_fault;

  // One extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid & out_ready;
  assign push  = !halted && !redirect_en && (!full || pop);

  assign misaligned = (fetch_pc[1:0] != 2'b00);
  assign push_fault = misaligned || imem_exc_en;

  // Misalignment is detected locally and overrides whatever memory returned.
  always_comb begin
    new_entry.pc       = fetch_pc;
    new_entry.instr    = imem_instr;
    new_entry.exc_en   = imem_exc_en;
    new_entry.exc_code = imem_exc_code;
    new_entry.exc_val  = imem_exc_val;
    if (misaligned) begin
      new_entry.instr    = NOP;
      new_entry.exc_en   = 1'b1;
      new_entry.exc_code = 4'd0;
      new_entry.exc_val  = fetch_pc;
    end else if (imem_exc_en) begin
      new_entry.instr = NOP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (push_fault) halted <= 1'b1;
        else            fetch_pc <= fetch_pc + 64'd4;
      end
    end
  end

  // NOTE: queue storage is not reset; the pointers alone define which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  always_comb begin
    out_valid    = !empty;
    out_instr    = NOP;
    out_pc       = '0;
    out_exc_en   = 1'b0;
    out_exc_code = '0;
    out_exc_val  = '0;
    if (!empty) begin
      out_instr    = head.instr;
      out_pc       = head.pc;
      out_exc_en   = head.exc_en;
      out_exc_code = head.exc_code;
      out_exc_val  = head.exc_val;
    end
  end

  assign imem_addr    = fetch_pc;
  assign fetch_halted = halted;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic        fetch_halted;

  logic        fault_on   = 1'b0;
  logic [63:0] fault_addr = 64'h0;

  int compared   = 0;
  int mismatched = 0;

  ifetch_queue #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
    .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_exc_en(out_exc_en), .out_exc_code(out_exc_code),
    .out_exc_val(out_exc_val), .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Instruction memory seen by the DUT.
  always_comb begin
    imem_instr    = mem_word(imem_addr);
    imem_exc_en   = fault_on && (imem_addr == fault_addr);
    imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
    imem_exc_val  = imem_exc_en ? imem_addr : 64'h0;
  end

  // What a fetch at pc must produce as a queue entry.
  function automatic ent_t fetch_model(input logic [63:0] pc);
    ent_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00) begin
      e.instr = NOP; e.exc_en = 1'b1; e.exc_code = 4'd0; e.exc_val = pc;
    end else if (fault_on && pc == fault_addr) begin
      e.instr = NOP; e.exc_en = 1'b1; e.exc_code = 4'd1; e.exc_val = pc;
    end else begin
      e.instr = mem_word(pc); e.exc_en = 1'b0; e.exc_code = 4'd0; e.exc_val = 64'h0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state advances at each negedge to represent the next posedge.
  ent_t        mq[$];
  ent_t        mh;
  ent_t        ne;
  logic [63:0] m_pc     = RPC;
  logic        m_halted = 1'b0;
  bit          model_on = 1'b0;
  bit          m_pop, m_push;

  always @(negedge clk) begin
    if (model_on) begin
      check("out_valid", {63'h0, out_valid}, {63'h0, mq.size() != 0});
      if (mq.size() != 0) begin
        mh = mq[0];
        check("out_pc", out_pc, mh.pc);
        check("out_instr", {32'h0, out_instr}, {32'h0, mh.instr});
        check("out_exc_en", {63'h0, out_exc_en}, {63'h0, mh.exc_en});
        check("out_exc_code", {60'h0, out_exc_code}, {60'h0, mh.exc_code});
        check("out_exc_val", out_exc_val, mh.exc_val);
      end else begin
        check("empty_pc", out_pc, 64'h0);
        check("empty_instr", {32'h0, out_instr}, {32'h0, NOP});
        check("empty_exc", {out_exc_val[58:0], out_exc_code, out_exc_en}, 64'h0);
      end
      check("imem_addr", imem_addr, m_pc);
      check("fetch_halted", {63'h0, fetch_halted}, {63'h0, m_halted});
    end
    if (rst) begin
      mq.delete(); m_pc = RPC; m_halted = 1'b0; model_on = 1'b1;
    end else if (redirect_en) begin
      mq.delete(); m_pc = redirect_pc; m_halted = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = !m_halted && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        ne = fetch_model(m_pc);
        mq.push_back(ne);
        if (ne.exc_en) m_halted = 1'b1;
        else           m_pc = m_pc + 64'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] pc, input logic ready);
    redirect_en = 1'b1;
    redirect_pc = pc;
    out_ready   = ready;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    tick(); tick();
    check("lit_reset_valid", {63'h0, out_valid}, 64'h0);
    check("lit_reset_addr", imem_addr, RPC);
    check("lit_reset_instr", {32'h0, out_instr}, {32'h0, NOP});
    rst = 1'b0;

    // Sequential stream with decode always ready.
    out_ready = 1'b1;
    tick();
    check("lit_seq_valid", {63'h0, out_valid}, 64'h1);
    check("lit_seq_pc0", out_pc, 64'h0);
    check("lit_seq_instr0", {32'h0, out_instr}, 64'hC0DE_0000);
    tick(); check("lit_seq_pc1", out_pc, 64'h4);
    tick(); check("lit_seq_pc2", out_pc, 64'h8);
    tick(); check("lit_seq_pc3", out_pc, 64'hC);
    check("lit_seq_instr3", {32'h0, out_instr}, 64'hC0DE_000C);

    // Backpressure: queue fills to 4, fetch stalls at 16, then drains with a
    // simultaneous pop and push on the full queue.
    redirect_to(64'h0, 1'b0);
    repeat (6) tick();
    check("lit_bp_addr", imem_addr, 64'h10);
    check("lit_bp_head", out_pc, 64'h0);
    out_ready = 1'b1;
    tick(); check("lit_bp_pc4", out_pc, 64'h4);
    check("lit_bp_addr2", imem_addr, 64'h14);
    tick(); check("lit_bp_pc8", out_pc, 64'h8);
    tick(); check("lit_bp_pc12", out_pc, 64'hC);
    tick(); check("lit_bp_pc16", out_pc, 64'h10);

    // Redirect with 3 entries queued and a pop pending.
    redirect_to(64'h0, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1;
    redirect_to(64'h40, 1'b1);
    check("lit_rd_flush", {63'h0, out_valid}, 64'h0);
    check("lit_rd_addr", imem_addr, 64'h40);
    tick(); check("lit_rd_pc40", out_pc, 64'h40);
    tick(); check("lit_rd_pc44", out_pc, 64'h44);

    // Access fault halts fetch; a redirect clears it.
    fault_addr = 64'h2000; fault_on = 1'b1;
    redirect_to(64'h2000, 1'b0);
    tick();
    check("lit_flt_exc_en", {63'h0, out_exc_en}, 64'h1);
    check("lit_flt_code", {60'h0, out_exc_code}, 64'h1);
    check("lit_flt_val", out_exc_val, 64'h2000);
    check("lit_flt_instr", {32'h0, out_instr}, {32'h0, NOP});
    check("lit_flt_halted", {63'h0, fetch_halted}, 64'h1);
    repeat (3) tick();
    check("lit_flt_hold", imem_addr, 64'h2000);
    out_ready = 1'b1;
    tick(); check("lit_flt_drained", {63'h0, out_valid}, 64'h0);
    tick(); check("lit_flt_nomore", {63'h0, out_valid}, 64'h0);
    redirect_to(64'h0, 1'b0);
    check("lit_flt_clear", {63'h0, fetch_halted}, 64'h0);
    fault_on = 1'b0;

    // Misaligned fetch.
    redirect_to(64'h42, 1'b0);
    tick();
    check("lit_mis_exc_en", {63'h0, out_exc_en}, 64'h1);
    check("lit_mis_code", {60'h0, out_exc_code}, 64'h0);
    check("lit_mis_val", out_exc_val, 64'h42);
    check("lit_mis_halted", {63'h0, fetch_halted}, 64'h1);
    out_ready = 1'b1;
    tick(); check("lit_mis_single", {63'h0, out_valid}, 64'h0);

    // 64-bit wrap-around of the fetch address.
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    tick(); tick();
    check("lit_wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("lit_wrap_addr", imem_addr, 64'h0);
    tick(); check("lit_wrap_pc0", out_pc, 64'h0);

    // Reset mid-stream discards queued entries.
    redirect_to(64'h100, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("lit_rst_valid", {63'h0, out_valid}, 64'h0);
    check("lit_rst_addr", imem_addr, RPC);
    out_ready = 1'b1;
    tick(); check("lit_rst_pc0", out_pc, RPC);
    check("lit_rst_valid2", {63'h0, out_valid}, 64'h1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch front end that sits between the PC/redirect logic and the decode stage and acts as the initiator toward the instruction memory. Each cycle it drives a fetch address to the combinational instruction memory, captures the returned instruction word and any access-fault information, and buffers them in a small FIFO with a valid/ready handshake toward decode. Branch and trap redirects flush the queue and restart fetch at the new PC. After a fault, fetch halts until the next redirect.

## Interface

- RESET_PC, 64'h0, fetch address loaded on reset
- FIFO_DEPTH, 4, queue entries; power of two, at least 2
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  64  fetch address, driven directly from the fetch_pc register
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- imem_exc_en  in  1  access fault for imem_addr
- imem_exc_code  in  4  fault cause (1 = instruction access fault)
- imem_exc_val  in  64  faulting address
- redirect_en  in  1  flush the queue and restart fetch
- redirect_pc  in  64  new fetch address
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts the head
- out_instr  out  32  head instruction
- out_pc  out  64  head PC
- out_exc_en  out  1  head carries an exception
- out_exc_code  out  4  head exception cause
- out_exc_val  out  64  head exception value
- fetch_halted  out  1  fetch stopped after an exception, waiting for a redirect

## Operation

- State: fetch_pc (64), halted (1), FIFO storage of {pc, instr, exc_en, exc_code, exc_val}, read and write pointers each log2(FIFO_DEPTH)+1 bits wide. Full and empty are decided by comparing pointer MSBs.
- Each entry's pc field holds the fetch_pc value used to fetch it.
- pop = out_valid & out_ready.
- push = !halted & !redirect_en & (!full | pop). A full queue therefore accepts a push in the same cycle as a pop.
- On push:
  - Write {fetch_pc, imem_instr, imem_exc_en, imem_exc_code, imem_exc_val}.
  - If imem_exc_en = 0: fetch_pc <= fetch_pc + 4, with 64-bit wrap-around (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
  - If imem_exc_en = 1: store instr as 32'h00000013, set halted, and hold fetch_pc.
- Misaligned fetch (fetch_pc[1:0] != 0) takes priority over the memory response. The pushed entry is exc_en = 1, exc_code = 0, exc_val = fetch_pc, instr = 32'h00000013, and halted is set.
- Redirect:
  - Both pointers are reset, so the queue is empty.
  - fetch_pc <= redirect_pc and halted <= 0.
  - No push and no pop take effect in that cycle; the out_* values shown that cycle are discarded.
- When the queue is empty: out_valid = 0, out_instr = 32'h00000013, and out_pc, out_exc_en, out_exc_code, out_exc_val are all 0.
- fetch_halted = halted.

## Timing

- Reset (rst high at an edge): fetch_pc = RESET_PC, halted = 0, queue empty. All out_* take their empty values, imem_addr = RESET_PC, fetch_halted = 0. rst overrides redirect_en and any handshake in the same cycle. Reset asserted mid-stream discards every queued entry.
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N appears at the head with out_valid = 1 after edge N if the queue was empty.
- With out_ready held at 1, throughput is 1 instruction per cycle.
- With out_ready = 0, the queue fills in FIFO_DEPTH cycles. fetch_pc then stalls, and imem_addr holds steady.
- Handshake rules:
  - out_valid, once high, stays high and out_* stay stable until pop or redirect.
  - out_valid may rise without out_ready.
- Simultaneous redirect and pop: the redirect wins and the popped entry is discarded; decode must ignore it.
- Redirect while halted restarts fetch at redirect_pc on the next cycle (imem_addr = redirect_pc after the edge).
- Exception entry latency matches a normal entry. Once halted, no further entries are pushed; entries already queued drain normally.

## Test plan

- Reset, then a sequential stream with out_ready = 1: out_pc = 0, 4, 8, 12 on consecutive cycles starting 1 cycle after reset release, and out_instr matches memory words 0..3.
- Backpressure (FIFO_DEPTH = 4, out_ready = 0 for 6 cycles): exactly 4 entries are pushed and imem_addr holds at 16. Release out_ready and check PCs 0, 4, 8, 12, 16 are delivered in order with no gap.
- Redirect to 0x40 while 3 entries are queued and out_ready = 1: out_valid = 0 on the next cycle, then out_pc = 0x40, 0x44.
- Access fault (imem_exc_en = 1, code 1, val 0x2000 at fetch_pc 0x2000): the entry shows out_exc_en = 1, out_exc_code = 1, out_exc_val = 0x2000, out_instr = 0x13. fetch_halted = 1 and no later entries appear. A redirect to 0 clears halted.
- Redirect to 0x42: a single entry with exc_code = 0, exc_val = 0x42, and fetch_halted = 1.
- Full queue with simultaneous pop and push: the count stays at 4 and the order is preserved. Assert rst for one cycle mid-stream: out_valid = 0 next cycle and imem_addr = RESET_PC.
